// File: rtl/pe16_req_scheduler_pkg.sv
// rtl/pe16_req_scheduler_pkg.sv - shared state encoding, widths and one-hot helper for the pe16 scheduler
package pe16_req_scheduler_pkg;

  localparam int PE_WIDTH = 16;
  localparam int PE_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ISSUE   = 2'd2
  } state_t;

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
  function automatic logic onehot_check(input logic [PE_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - {{(PE_WIDTH-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/pe16_req_scheduler_onehot16_to_idx4.sv
// rtl/pe16_req_scheduler_onehot16_to_idx4.sv - 16-bit one-hot to 4-bit index with one-hot valid flag
module onehot16_to_idx4
  import pe16_req_scheduler_pkg::*;
(
  input  logic [PE_WIDTH-1:0] onehot,
  output logic [PE_IDX_W-1:0] idx,
  output logic                valid
);

  // OR of set-bit positions; only meaningful when valid is high.
  always_comb begin
    idx = '0;
    for (int i = 0; i < PE_WIDTH; i++) begin
      if (onehot[i]) idx = idx | PE_IDX_W'(i);
    end
  end

  assign valid = onehot_check(onehot);

endmodule

// File: rtl/pe16_req_scheduler.sv
// rtl/pe16_req_scheduler.sv - sticky request accumulator issuing pe16b winners over valid/ready
module pe16_req_scheduler
  import pe16_req_scheduler_pkg::*;
#(
  parameter int WIDTH     = PE_WIDTH,
  parameter int IDX_W     = PE_IDX_W,
  parameter int MAX_STALL = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_in,
  output logic [WIDTH-1:0] pe_in,
  input  logic [WIDTH-1:0] pe_out,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic [IDX_W-1:0] grant_idx,
  output logic [WIDTH-1:0] grant_onehot,
  output logic [WIDTH-1:0] pending,
  output logic             busy,
  output logic             err_onehot,
  output logic             err_timeout
);

  localparam logic [7:0] STALL_LIM = 8'(MAX_STALL - 1);

  state_t             state, state_next;
  logic [7:0]         stall_cnt;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_valid;
  logic               handshake;
  logic               stall_done;
  logic [WIDTH-1:0]   pending_next;

  onehot16_to_idx4 u_enc (
    .onehot (pe_out),
    .idx    (enc_idx),
    .valid  (enc_valid)
  );

  assign grant_valid  = (state == ST_ISSUE);
  assign busy         = (state != ST_IDLE);
  assign pe_in        = pending;
  assign handshake    = grant_valid & grant_ready;
  // OR-ing req_in last lets a same-cycle re-request survive its own retirement.
  assign pending_next = (pending & ~(handshake ? grant_onehot : '0)) | req_in;
  assign stall_done   = grant_valid && !grant_ready && (stall_cnt >= STALL_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (pending != '0) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = enc_valid ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: begin
        if (grant_ready)     state_next = (pending_next != '0) ? ST_CAPTURE : ST_IDLE;
        else if (stall_done) state_next = ST_IDLE;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      grant_onehot <= '0;
      grant_idx    <= '0;
      stall_cnt    <= '0;
      err_onehot   <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      pending <= pending_next;
      if (state == ST_CAPTURE) begin
        grant_onehot <= pe_out;
        grant_idx    <= enc_idx;
        if (!enc_valid) err_onehot <= 1'b1;
      end
      if (stall_done) err_timeout <= 1'b1;
      // Held at zero outside ISSUE, so every offer starts its stall count fresh.
      if (state != ST_ISSUE)
        stall_cnt <= '0;
      else if (!grant_ready && stall_cnt != 8'hFF)
        stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pe16_req_scheduler.sv
// tb/tb_pe16_req_scheduler.sv - directed vector bench for pe16_req_scheduler with a pe16b model
module tb_pe16_req_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req_in = '0;
  logic        grant_ready = 1'b0;
  logic [15:0] pe_in, pe_out, grant_onehot, pending;
  logic        grant_valid, busy, err_onehot, err_timeout;
  logic [3:0]  grant_idx;
  logic        stub_en = 1'b0;
  logic [15:0] stub_val = '0;

  logic [15:0] req_in_s = '0;
  logic        grant_ready_s = 1'b0;
  logic [15:0] pe_in_s, pe_out_s, grant_onehot_s, pending_s;
  logic        grant_valid_s, busy_s, err_onehot_s, err_timeout_s;
  logic [3:0]  grant_idx_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] hi_onehot(input logic [15:0] v);
    hi_onehot = '0;
    for (int i = 0; i < 16; i++) if (v[i]) hi_onehot = 16'd1 << i;
  endfunction

  assign pe_out   = stub_en ? stub_val : hi_onehot(pe_in);
  assign pe_out_s = hi_onehot(pe_in_s);

  pe16_req_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .pe_in(pe_in), .pe_out(pe_out),
    .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_idx(grant_idx),
    .grant_onehot(grant_onehot), .pending(pending), .busy(busy),
    .err_onehot(err_onehot), .err_timeout(err_timeout)
  );

  pe16_req_scheduler #(.MAX_STALL(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_in(req_in_s), .pe_in(pe_in_s), .pe_out(pe_out_s),
    .grant_valid(grant_valid_s), .grant_ready(grant_ready_s), .grant_idx(grant_idx_s),
    .grant_onehot(grant_onehot_s), .pending(pending_s), .busy(busy_s),
    .err_onehot(err_onehot_s), .err_timeout(err_timeout_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] req;
    logic        rdy;
    logic        valid;
    logic [3:0]  idx;
    logic [15:0] pend;
    logic        busy;
  } vec_t;

  vec_t vt[15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    int vcnt;

    // req 0x0124 drained highest first, then a same-cycle re-request of bit 3
    vt[0]  = '{16'h0124, 1'b1, 1'b0, 4'd0, 16'h0124, 1'b0};
    vt[1]  = '{16'h0000, 1'b1, 1'b0, 4'd0, 16'h0124, 1'b1};
    vt[2]  = '{16'h0000, 1'b1, 1'b1, 4'd8, 16'h0124, 1'b1};
    vt[3]  = '{16'h0000, 1'b1, 1'b0, 4'd0, 16'h0024, 1'b1};
    vt[4]  = '{16'h0000, 1'b1, 1'b1, 4'd5, 16'h0024, 1'b1};
    vt[5]  = '{16'h0000, 1'b1, 1'b0, 4'd0, 16'h0004, 1'b1};
    vt[6]  = '{16'h0000, 1'b1, 1'b1, 4'd2, 16'h0004, 1'b1};
    vt[7]  = '{16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0};
    vt[8]  = '{16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0};
    vt[9]  = '{16'h0008, 1'b1, 1'b0, 4'd0, 16'h0008, 1'b0};
    vt[10] = '{16'h0000, 1'b1, 1'b0, 4'd0, 16'h0008, 1'b1};
    vt[11] = '{16'h0000, 1'b1, 1'b1, 4'd3, 16'h0008, 1'b1};
    vt[12] = '{16'h0008, 1'b1, 1'b0, 4'd0, 16'h0008, 1'b1};
    vt[13] = '{16'h0000, 1'b1, 1'b1, 4'd3, 16'h0008, 1'b1};
    vt[14] = '{16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", grant_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_onehot", grant_onehot, 0);
    check("rst_errs", {err_onehot, err_timeout}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      req_in      = vt[i].req;
      grant_ready = vt[i].rdy;
      tick();
      req_in = '0;
      check($sformatf("v%0d_valid", i), grant_valid, vt[i].valid);
      check($sformatf("v%0d_busy", i), busy, vt[i].busy);
      check($sformatf("v%0d_pending", i), pending, vt[i].pend);
      if (vt[i].valid) begin
        check($sformatf("v%0d_idx", i), grant_idx, vt[i].idx);
        check($sformatf("v%0d_onehot", i), grant_onehot, 16'd1 << vt[i].idx);
      end
    end

    // stalled grant on bit 15 holds steady for 10 cycles
    grant_ready = 1'b0;
    req_in = 16'h8000;
    tick();
    req_in = '0;
    tick();
    tick();
    check("stall_valid0", grant_valid, 1);
    check("stall_idx0", grant_idx, 15);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("stall%0d", k), {grant_valid, grant_idx, grant_onehot}, {1'b1, 4'd15, 16'h8000});
    end
    grant_ready = 1'b1;
    tick();
    check("stall_retire", {grant_valid, busy, pending}, 0);
    check("stall_no_timeout", err_timeout, 0);

    // non one-hot pe_out from a stubbed encoder
    check("err_onehot_pre", err_onehot, 0);
    stub_en  = 1'b1;
    stub_val = 16'h0003;
    req_in   = 16'h0010;
    tick();
    req_in = '0;
    tick();
    tick();
    check("err_onehot", err_onehot, 1);
    check("err_idle", {busy, grant_valid}, 0);
    check("err_pending", pending, 16'h0010);
    stub_en = 1'b0;
    seen = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (grant_valid) seen = int'(grant_idx);
      if (pending == '0 && !busy) break;
    end
    check("err_recover_idx", seen, 4);
    check("err_recover_pending", pending, 0);
    check("err_onehot_sticky", err_onehot, 1);

    // timeout with MAX_STALL = 4
    req_in_s = 16'h0002;
    tick();
    req_in_s = '0;
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (grant_valid_s) vcnt++;
      else if (vcnt > 0) break;
    end
    check("to_valid_cycles", vcnt, 4);
    check("to_err", err_timeout_s, 1);
    check("to_pending", pending_s, 16'h0002);
    check("to_idle", {busy_s, grant_valid_s}, 0);

    // asynchronous reset in the middle of an offer
    grant_ready = 1'b0;
    req_in = 16'h0040;
    tick();
    req_in = '0;
    tick();
    tick();
    check("ar_valid", grant_valid, 1);
    check("ar_idx", grant_idx, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_grant", {grant_valid, grant_idx, grant_onehot}, 0);
    check("ar_pend", {pending, pe_in}, 0);
    check("ar_flags", {busy, err_onehot, err_timeout, err_timeout_s}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    grant_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("ar_quiet%0d", k), {grant_valid, busy, pending}, 0);
    end
    req_in = 16'h0001;
    tick();
    req_in = '0;
    tick();
    tick();
    check("ar_new_valid", grant_valid, 1);
    check("ar_new_idx", grant_idx, 0);
    tick();
    check("ar_new_retire", {grant_valid, pending}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
